// File: rtl/ct_vfalu_dp_wb_pipe7.sv
// Pipe7 ex4 writeback register. It holds the ex3 result until the register-file port grants it.
// It also back-pressures ex3, accumulates sticky fflags and flags bad result selects.
module ct_vfalu_dp_wb_pipe7 #(
  parameter int DATA_W = 64,
  parameter int PREG_W = 7
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              rtu_yy_xx_flush,
  input  logic              ex3_inst_vld,
  input  logic [PREG_W-1:0] ex3_dst_preg,
  input  logic              fadd_forward_r_vld,
  input  logic              fcnvt_forward_r_vld,
  input  logic              fspu_forward_r_vld,
  input  logic [DATA_W-1:0] ex3_freg_data,
  input  logic [4:0]        ex3_ereg_data,
  input  logic              ex3_ereg_vld,
  input  logic              wb_grant,
  input  logic              fflags_clr,
  output logic              ex3_stall,
  output logic              ex4_wb_vld,
  output logic [PREG_W-1:0] ex4_wb_preg,
  output logic [DATA_W-1:0] ex4_wb_data,
  output logic [4:0]        ex4_wb_fflags,
  output logic [4:0]        vfalu_fflags_acc,
  output logic              sel_onehot_err
);

  logic [1:0] sel_cnt;
  logic       sel_one;
  logic       wb_fire;
  logic       ex3_take;

  assign sel_cnt  = {1'b0, fadd_forward_r_vld} + {1'b0, fcnvt_forward_r_vld}
                  + {1'b0, fspu_forward_r_vld};
  assign sel_one  = (sel_cnt == 2'd1);
  assign wb_fire  = ex4_wb_vld & wb_grant;
  assign ex3_stall = ex4_wb_vld & ~wb_grant;
  assign ex3_take = ex3_inst_vld & ~ex3_stall & ~rtu_yy_xx_flush;

  // A take and a fire in the same cycle reload ex4, so the pipe sustains one result per cycle.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ex4_wb_vld <= 1'b0;
    end else if (rtu_yy_xx_flush) begin
      ex4_wb_vld <= 1'b0;
    end else if (ex3_take) begin
      ex4_wb_vld <= 1'b1;
    end else if (wb_fire) begin
      ex4_wb_vld <= 1'b0;
    end
  end

  // An illegal select captures zero data, so a bad mux never leaks a mixed value.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ex4_wb_preg   <= '0;
      ex4_wb_data   <= '0;
      ex4_wb_fflags <= '0;
    end else if (ex3_take) begin
      ex4_wb_preg   <= ex3_dst_preg;
      ex4_wb_data   <= sel_one ? ex3_freg_data : '0;
      ex4_wb_fflags <= ex3_ereg_data & {5{ex3_ereg_vld}};
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      vfalu_fflags_acc <= '0;
      sel_onehot_err   <= 1'b0;
    end else begin
      vfalu_fflags_acc <= (fflags_clr ? 5'd0 : vfalu_fflags_acc)
                        | ((wb_fire & ~rtu_yy_xx_flush) ? ex4_wb_fflags : 5'd0);
      if ((ex3_inst_vld & (sel_cnt > 2'd1)) | (ex3_take & (sel_cnt == 2'd0)))
        sel_onehot_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_vfalu_dp_wb_pipe7.sv
// Directed, table-driven bench for the pipe7 ex4 writeback stage.
// Each vector is one cycle of stimulus paired with the outputs expected after that cycle.
module tb_ct_vfalu_dp_wb_pipe7;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inst_vld;
  logic [6:0]  dst_preg;
  logic        fadd_vld;
  logic        fcnvt_vld;
  logic        fspu_vld;
  logic [63:0] freg_data;
  logic [4:0]  ereg_data;
  logic        ereg_vld;
  logic        grant;
  logic        clr;
  logic        stall;
  logic        wb_vld;
  logic [6:0]  wb_preg;
  logic [63:0] wb_data;
  logic [4:0]  wb_fflags;
  logic [4:0]  acc;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  ct_vfalu_dp_wb_pipe7 #(.DATA_W(64), .PREG_W(7)) dut (
    .forever_cpuclk      (clk),
    .cpurst              (rst),
    .rtu_yy_xx_flush     (flush),
    .ex3_inst_vld        (inst_vld),
    .ex3_dst_preg        (dst_preg),
    .fadd_forward_r_vld  (fadd_vld),
    .fcnvt_forward_r_vld (fcnvt_vld),
    .fspu_forward_r_vld  (fspu_vld),
    .ex3_freg_data       (freg_data),
    .ex3_ereg_data       (ereg_data),
    .ex3_ereg_vld        (ereg_vld),
    .wb_grant            (grant),
    .fflags_clr          (clr),
    .ex3_stall           (stall),
    .ex4_wb_vld          (wb_vld),
    .ex4_wb_preg         (wb_preg),
    .ex4_wb_data         (wb_data),
    .ex4_wb_fflags       (wb_fflags),
    .vfalu_fflags_acc    (acc),
    .sel_onehot_err      (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [6:0]  preg;
    logic [63:0] data;
    logic        evld;
    logic [4:0]  ereg;
    logic        g;
    logic        fl;
    logic        c;
    logic        e_stall;
    logic        e_vld;
    logic [6:0]  e_preg;
    logic [63:0] e_data;
    logic [4:0]  e_ff;
    logic [4:0]  e_acc;
    logic        e_err;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic vld, input logic [2:0] sel, input logic [6:0] preg,
                              input logic [63:0] data, input logic evld, input logic [4:0] ereg,
                              input logic g, input logic fl, input logic c,
                              input logic e_stall, input logic e_vld, input logic [6:0] e_preg,
                              input logic [63:0] e_data, input logic [4:0] e_ff,
                              input logic [4:0] e_acc, input logic e_err);
    vec_t v;
    v.vld = vld; v.sel = sel; v.preg = preg; v.data = data; v.evld = evld; v.ereg = ereg;
    v.g = g; v.fl = fl; v.c = c; v.e_stall = e_stall; v.e_vld = e_vld; v.e_preg = e_preg;
    v.e_data = e_data; v.e_ff = e_ff; v.e_acc = e_acc; v.e_err = e_err;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [2:0] sel, input logic [6:0] preg,
                       input logic [63:0] data, input logic evld, input logic [4:0] ereg,
                       input logic g, input logic fl, input logic c);
    inst_vld = vld; fadd_vld = sel[2]; fcnvt_vld = sel[1]; fspu_vld = sel[0];
    dst_preg = preg; freg_data = data; ereg_vld = evld; ereg_data = ereg;
    grant = g; flush = fl; clr = c;
  endtask

  task automatic check_regs(input string tag, input logic e_vld, input logic [6:0] e_preg,
                            input logic [63:0] e_data, input logic [4:0] e_ff,
                            input logic [4:0] e_acc, input logic e_err);
    check_output({tag, ".vld"},    64'(wb_vld),    64'(e_vld));
    check_output({tag, ".preg"},   64'(wb_preg),   64'(e_preg));
    check_output({tag, ".data"},   wb_data,        e_data);
    check_output({tag, ".fflags"}, 64'(wb_fflags), 64'(e_ff));
    check_output({tag, ".acc"},    64'(acc),       64'(e_acc));
    check_output({tag, ".err"},    64'(sel_err),   64'(e_err));
  endtask

  task automatic apply_stimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    drive(v.vld, v.sel, v.preg, v.data, v.evld, v.ereg, v.g, v.fl, v.c);
    #1;
    check_output($sformatf("v%0d.stall", idx), 64'(stall), 64'(v.e_stall));
    @(posedge clk);
    #1;
    check_regs($sformatf("v%0d", idx), v.e_vld, v.e_preg, v.e_data, v.e_ff, v.e_acc, v.e_err);
  endtask

  localparam logic [63:0] D1 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] DC = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DE = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] DF = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DG = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] DH = 64'hC000_0000_0000_0001;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    // sel bits are {fadd, fcnvt, fspu}
    vecs[0]  = mk(1, 3'b100, 7'd12, D1, 1, 5'h01, 1, 0, 0,  0, 1, 7'd12, D1, 5'h01, 5'h00, 0);
    vecs[1]  = mk(0, 3'b000, 7'd0,  0,  0, 5'h00, 1, 0, 0,  0, 0, 7'd12, D1, 5'h01, 5'h01, 0);
    vecs[2]  = mk(1, 3'b010, 7'd20, DA, 1, 5'h02, 0, 0, 0,  0, 1, 7'd20, DA, 5'h02, 5'h01, 0);
    vecs[3]  = mk(1, 3'b001, 7'd21, DB, 0, 5'h04, 0, 0, 0,  1, 1, 7'd20, DA, 5'h02, 5'h01, 0);
    vecs[4]  = mk(1, 3'b001, 7'd21, DB, 0, 5'h04, 0, 0, 0,  1, 1, 7'd20, DA, 5'h02, 5'h01, 0);
    vecs[5]  = mk(1, 3'b001, 7'd21, DB, 0, 5'h04, 0, 0, 0,  1, 1, 7'd20, DA, 5'h02, 5'h01, 0);
    vecs[6]  = mk(1, 3'b001, 7'd21, DB, 0, 5'h04, 1, 0, 0,  0, 1, 7'd21, DB, 5'h00, 5'h03, 0);
    vecs[7]  = mk(1, 3'b100, 7'd30, DC, 1, 5'h10, 1, 0, 0,  0, 1, 7'd30, DC, 5'h10, 5'h03, 0);
    vecs[8]  = mk(1, 3'b100, 7'd31, 64'd5, 1, 5'h08, 1, 1, 0, 0, 0, 7'd30, DC, 5'h10, 5'h03, 0);
    vecs[9]  = mk(0, 3'b000, 7'd0,  0,  0, 5'h00, 1, 0, 0,  0, 0, 7'd30, DC, 5'h10, 5'h03, 0);
    vecs[10] = mk(1, 3'b010, 7'd40, DE, 1, 5'h06, 0, 0, 1,  0, 1, 7'd40, DE, 5'h06, 5'h00, 0);
    vecs[11] = mk(0, 3'b000, 7'd0,  0,  0, 5'h00, 1, 0, 0,  0, 0, 7'd40, DE, 5'h06, 5'h06, 0);
    vecs[12] = mk(1, 3'b100, 7'd41, DF, 1, 5'h08, 0, 0, 0,  0, 1, 7'd41, DF, 5'h08, 5'h06, 0);
    vecs[13] = mk(0, 3'b000, 7'd0,  0,  0, 5'h00, 1, 0, 1,  0, 0, 7'd41, DF, 5'h08, 5'h08, 0);
    vecs[14] = mk(1, 3'b001, 7'd50, DG, 1, 5'h01, 1, 0, 0,  0, 1, 7'd50, DG, 5'h01, 5'h08, 0);
    vecs[15] = mk(1, 3'b100, 7'd51, DH, 1, 5'h04, 1, 0, 0,  0, 1, 7'd51, DH, 5'h04, 5'h09, 0);
    vecs[16] = mk(0, 3'b000, 7'd0,  0,  0, 5'h00, 1, 0, 0,  0, 0, 7'd51, DH, 5'h04, 5'h0D, 0);
    vecs[17] = mk(1, 3'b101, 7'd60, DX, 1, 5'h03, 1, 0, 0,  0, 1, 7'd60, 0,  5'h03, 5'h0D, 1);
    vecs[18] = mk(0, 3'b000, 7'd0,  0,  0, 5'h00, 1, 0, 0,  0, 0, 7'd60, 0,  5'h03, 5'h0F, 1);

    rst = 1'b1;
    drive(0, 3'b000, 7'd0, 64'd0, 0, 5'h00, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_regs("in_reset", 0, 7'd0, 64'd0, 5'h00, 5'h00, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("idle.stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    check_regs("post_reset", 0, 7'd0, 64'd0, 5'h00, 5'h00, 0);

    for (int i = 0; i < 19; i++) apply_stimulus(i);

    // Reset arriving mid-stall must discard the entry and the sticky error
    @(negedge clk);
    drive(1, 3'b100, 7'd70, D1, 1, 5'h01, 0, 0, 0);
    @(posedge clk);
    #1;
    check_output("rst_mid.vld_before", 64'(wb_vld), 64'd1);
    @(negedge clk);
    #1;
    check_output("rst_mid.stall_before", 64'(stall), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_regs("rst_mid", 0, 7'd0, 64'd0, 5'h00, 5'h00, 0);
    check_output("rst_mid.stall", 64'(stall), 64'd0);
    @(negedge clk);
    drive(0, 3'b000, 7'd0, 64'd0, 0, 5'h00, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs("rst_release", 0, 7'd0, 64'd0, 5'h00, 5'h00, 0);

    // A taken instruction with no select asserted is also an illegal select
    @(negedge clk);
    drive(1, 3'b000, 7'd5, D1, 0, 5'h1F, 0, 0, 0);
    @(posedge clk);
    #1;
    check_regs("no_sel", 1, 7'd5, 64'd0, 5'h00, 5'h00, 1);
    @(negedge clk);
    drive(0, 3'b000, 7'd0, 64'd0, 0, 5'h00, 1, 0, 0);
    @(posedge clk);
    #1;
    check_regs("no_sel_drain", 0, 7'd5, 64'd0, 5'h00, 5'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
